// File: rtl/coll_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coll_evt_pkg
// Brief    : Shared types and constants for the collision event encoder.
// Revision : 1.0 - initial release
// ============================================================================
package coll_evt_pkg;

    typedef logic [7:0] evt_code_t;

    localparam evt_code_t c_BASE_CODE_DEFAULT = 8'h40;
    localparam int        c_MAX_NUM_CH        = 16;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [3:0] first_idx(input logic [c_MAX_NUM_CH-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = c_MAX_NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coll_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : coll_evt_fifo
// Brief    : Synchronous code queue; a pop frees a slot for a same-cycle push.
// Revision : 1.0 - initial release
// ============================================================================
module coll_evt_fifo
    import coll_evt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  evt_code_t              i_push_data,
    input  logic                   i_pop,
    output evt_code_t              o_head_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam int                c_CW      = c_AW + 1;
    localparam logic [c_AW:0]     c_FULL    = c_CW'(DEPTH);
    localparam logic [c_AW:0]     c_ONE     = c_CW'(1);
    localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);

    evt_code_t         r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/coll_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : coll_event_encoder
// Brief    : Synchronizes level events, detects rising edges and queues one
//            code per cycle, lowest channel first. Optional debounce filter
//            is compiled in with COLL_EVT_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module coll_event_encoder
    import coll_evt_pkg::*;
#(
    parameter int        NUM_CH       = 6,
    parameter int        FIFO_DEPTH   = 8,
    parameter evt_code_t BASE_CODE    = c_BASE_CODE_DEFAULT,
    parameter int        DEBOUNCE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           evt_in,
    input  logic                        clr_ovf,
    input  logic                        tx_ready,
    output logic                        tx_valid,
    output logic [7:0]                  tx_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

`ifdef COLL_EVT_DEBOUNCE_EN
    localparam int c_ARM_CYC = 2 + DEBOUNCE_CYC;
`else
    localparam int c_ARM_CYC = 2;
`endif
    // Sized for the debounce build so one width serves both variants.
    localparam int                  c_ARM_W   = $clog2(DEBOUNCE_CYC + 4);
    localparam logic [c_ARM_W-1:0]  c_ARMED   = c_ARM_W'(c_ARM_CYC + 1);
    localparam logic [c_ARM_W-1:0]  c_ARM_ONE = c_ARM_W'(1);

    logic [NUM_CH-1:0]       r_sync1;
    logic [NUM_CH-1:0]       r_sync2;
    logic [NUM_CH-1:0]       w_level;
    logic [NUM_CH-1:0]       r_level_d;
    logic [NUM_CH-1:0]       w_rise;
    logic [NUM_CH-1:0]       r_pending;
    logic [NUM_CH-1:0]       w_grant;
    logic [NUM_CH-1:0]       w_drop;
    logic [c_MAX_NUM_CH-1:0] w_pending_ext;
    logic [3:0]              w_grant_idx;
    logic [c_ARM_W-1:0]      r_arm_cnt;
    logic                    w_armed;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_can_push;
    logic                    w_push;
    evt_code_t               w_code;
    logic                    r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level_d <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_sync1   <= evt_in;
            r_sync2   <= r_sync1;
            r_level_d <= w_level;
            if (r_arm_cnt != c_ARMED) r_arm_cnt <= r_arm_cnt + c_ARM_ONE;
        end
    end

`ifdef COLL_EVT_DEBOUNCE_EN
    localparam int                c_DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_DB_W-1:0] c_DB_SAT = c_DB_W'(DEBOUNCE_CYC);
    localparam logic [c_DB_W-1:0] c_DB_PRE = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE = c_DB_W'(1);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_debounce
        logic [c_DB_W-1:0] r_cnt;
        logic              r_qual;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_qual <= 1'b0;
            end else if (!r_sync2[g]) begin
                r_cnt  <= '0;
                r_qual <= 1'b0;
            end else begin
                if (r_cnt != c_DB_SAT) r_cnt <= r_cnt + c_DB_ONE;
                r_qual <= (r_cnt == c_DB_PRE) || (r_cnt == c_DB_SAT);
            end
        end

        assign w_level[g] = r_qual;
    end
`else
    assign w_level = r_sync2;
`endif

    // Edges are masked until the pipeline has refilled after reset, so a
    // level held high across release is not mistaken for a new event.
    assign w_armed = (r_arm_cnt == c_ARMED);
    assign w_rise  = w_level & ~r_level_d & {NUM_CH{w_armed}};

    assign w_can_push    = ~w_full | (tx_ready & ~w_empty);
    assign w_push        = (|r_pending) & w_can_push;
    assign w_grant       = w_push ? (r_pending & (-r_pending)) : '0;
    assign w_pending_ext = c_MAX_NUM_CH'(r_pending);
    assign w_grant_idx   = first_idx(w_pending_ext);
    assign w_code        = BASE_CODE + evt_code_t'(w_grant_idx);
    assign w_drop        = w_rise & r_pending & ~w_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_rise;
            if (|w_drop)      r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
        end
    end

    coll_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_code),
        .i_pop       (tx_ready),
        .o_head_data (tx_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    assign tx_valid = ~w_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coll_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_coll_event_encoder
// Brief    : Self-checking bench: directed tables, corner sequences and a
//            randomized run against a sample-window/queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coll_event_encoder;

    localparam int NCH   = 12;
    localparam int DEPTH = 8;
    localparam int DB    = 4;
`ifdef COLL_EVT_DEBOUNCE_EN
    localparam int DB_LAT = DB;
`else
    localparam int DB_LAT = 0;
`endif
    localparam int PW  = (DB_LAT > 0) ? DB_LAT : 1;
    localparam int LAT = 3 + DB_LAT;

    logic           clk      = 1'b0;
    logic           reset    = 1'b0;
    logic [NCH-1:0] evt_in   = '0;
    logic           clr_ovf  = 1'b0;
    logic           tx_ready = 1'b0;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic [3:0]     fifo_count;
    logic           overflow;

    always #5 clk = ~clk;

    coll_event_encoder #(
        .NUM_CH       (NCH),
        .FIFO_DEPTH   (DEPTH),
        .BASE_CODE    (8'h40),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .evt_in     (evt_in),
        .clr_ovf    (clr_ovf),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: samples per edge since release, pending set, code queue.
    logic [NCH-1:0] samp [0:16383];
    int             m_edge = 0;
    logic [NCH-1:0] m_pend = '0;
    logic [7:0]     m_q [$];
    bit             m_ovf  = 1'b0;

    function automatic logic [NCH-1:0] samp_at(input int j);
        return (j >= 1 && j <= m_edge) ? samp[j] : '0;
    endfunction

    // Qualified level after edge m: high when the required window of samples was high.
    function automatic logic [NCH-1:0] qual(input int m);
        logic [NCH-1:0] acc;
        int lo, hi;
        acc = '1;
        lo  = m - 1 - DB_LAT;
        hi  = (DB_LAT > 0) ? m - 2 : m - 1;
        for (int j = lo; j <= hi; j++) acc &= samp_at(j);
        return acc;
    endfunction

    task automatic model_reset();
        m_edge = 0;
        m_pend = '0;
        m_q.delete();
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] rise;
        bit pop, can_push;
        int idx;
        m_edge++;
        samp[m_edge] = evt_in;
        rise = (m_edge >= 4 + DB_LAT) ? (qual(m_edge - 1) & ~qual(m_edge - 2)) : '0;
        pop      = (m_q.size() > 0) && tx_ready;
        can_push = (m_q.size() < DEPTH) || pop;
        idx = -1;
        if (can_push)
            for (int i = 0; i < NCH; i++)
                if (m_pend[i] && idx < 0) idx = i;
        if (pop) void'(m_q.pop_front());
        if (idx >= 0) begin
            m_q.push_back(8'h40 + 8'(idx));
            m_pend[idx] = 1'b0;
        end
        if (|(rise & m_pend)) m_ovf = 1'b1;
        else if (clr_ovf)     m_ovf = 1'b0;
        m_pend |= rise;
    endtask

    task automatic compare_model();
        check("model_valid", int'(tx_valid), int'(m_q.size() > 0));
        check("model_count", int'(fifo_count), m_q.size());
        check("model_ovf", int'(overflow), int'(m_ovf));
        if (m_q.size() > 0) check("model_data", int'(tx_data), int'(m_q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        if (reset) compare_model();
    endtask

    typedef struct {
        logic [NCH-1:0] evt;
        bit             rdy;
        bit             valid;
        logic [7:0]     data;
        int             cnt;
    } vec_t;

    vec_t tbl [32];

    initial begin
        int beats, n41, ntot, rdy_bias;
        logic [7:0] got [$];

        for (int r = 0; r < 32; r++)
            tbl[r] = '{evt: '0, rdy: 1'b1, valid: 1'b0, data: 8'h00, cnt: 0};
        for (int r = 0; r < PW; r++) begin
            tbl[r].evt      = 12'h004;
            tbl[16 + r].evt = 12'h029;
        end
        tbl[LAT]      = '{evt: '0, rdy: 1'b1, valid: 1'b1, data: 8'h42, cnt: 1};
        tbl[16 + LAT] = '{evt: '0, rdy: 1'b1, valid: 1'b1, data: 8'h40, cnt: 1};
        tbl[17 + LAT] = '{evt: '0, rdy: 1'b1, valid: 1'b1, data: 8'h43, cnt: 1};
        tbl[18 + LAT] = '{evt: '0, rdy: 1'b1, valid: 1'b1, data: 8'h45, cnt: 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(tx_valid), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_ovf", int'(overflow), 0);
        check("reset_data", int'(tx_data), 0);
        model_reset();
        reset = 1'b1;
        repeat (6) step();

        // Single pulse latency and simultaneous-edge ordering.
        for (int r = 0; r < 32; r++) begin
            evt_in   = tbl[r].evt;
            tx_ready = tbl[r].rdy;
            step();
            check($sformatf("tbl[%0d].valid", r), int'(tx_valid), int'(tbl[r].valid));
            check($sformatf("tbl[%0d].count", r), int'(fifo_count), tbl[r].cnt);
            check($sformatf("tbl[%0d].ovf", r), int'(overflow), 0);
            if (tbl[r].valid) check($sformatf("tbl[%0d].data", r), int'(tx_data), int'(tbl[r].data));
        end

        // Ten edges into an eight-deep queue with the consumer stalled.
        tx_ready = 1'b0;
        evt_in   = 12'h3FF;
        repeat (PW) step();
        evt_in = '0;
        repeat (20 + DB_LAT) step();
        check("fill_count", int'(fifo_count), 8);
        check("fill_ovf", int'(overflow), 0);
        tx_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 30; c++) begin
            if (tx_valid) got.push_back(tx_data);
            step();
            if (c == 0) check("full_pushpop_count", int'(fifo_count), 8);
        end
        check("fill_drain_n", got.size(), 10);
        for (int k = 0; k < got.size() && k < 10; k++)
            check($sformatf("fill_drain[%0d]", k), int'(got[k]), 8'h40 + k);
        check("fill_drain_ovf", int'(overflow), 0);

        // Second edge on a channel still pending behind a full queue.
        tx_ready = 1'b0;
        evt_in   = 12'h1FD;
        repeat (PW) step();
        evt_in = '0;
        repeat (12 + DB_LAT) step();
        check("ovf_fill_count", int'(fifo_count), 8);
        evt_in = 12'h002;
        repeat (PW) step();
        evt_in = '0;
        repeat (3) step();
        evt_in = 12'h002;
        repeat (PW) step();
        evt_in = '0;
        repeat (8 + DB_LAT) step();
        check("ovf_set", int'(overflow), 1);
        tx_ready = 1'b1;
        n41 = 0;
        ntot = 0;
        repeat (20) begin
            if (tx_valid) begin
                ntot++;
                if (tx_data == 8'h41) n41++;
            end
            step();
        end
        check("ovf_code41_once", n41, 1);
        check("ovf_drain_n", ntot, 9);
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Reset with queued entries and an input held high through release.
        tx_ready = 1'b0;
        evt_in   = 12'h007;
        repeat (PW) step();
        evt_in = '0;
        repeat (10 + DB_LAT) step();
        check("rst_pre_count", int'(fifo_count), 3);
        evt_in[11] = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_valid", int'(tx_valid), 0);
        check("rst_async_count", int'(fifo_count), 0);
        check("rst_async_data", int'(tx_data), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        tx_ready = 1'b1;
        beats    = 0;
        repeat (20) begin
            step();
            if (tx_valid) beats++;
        end
        check("rst_no_codes", beats, 0);
        evt_in = '0;
        repeat (5) step();

`ifdef COLL_EVT_DEBOUNCE_EN
        beats = 0;
        evt_in[4] = 1'b1;
        repeat (3) begin
            step();
            if (tx_valid) beats++;
        end
        evt_in[4] = 1'b0;
        repeat (15) begin
            step();
            if (tx_valid) beats++;
        end
        check("db_glitch_beats", beats, 0);
        beats = 0;
        evt_in[4] = 1'b1;
        repeat (6) begin
            step();
            if (tx_valid) beats++;
        end
        evt_in[4] = 1'b0;
        repeat (15) begin
            if (tx_valid) check("db_long_data", int'(tx_data), 8'h44);
            step();
            if (tx_valid) beats++;
        end
        check("db_long_beats", beats, 1);
`endif

        // Randomized traffic against the reference model.
        rdy_bias = 2;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) rdy_bias = $urandom_range(0, 4);
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 5) == 0) evt_in[i] = ~evt_in[i];
            tx_ready = ($urandom_range(0, 3) < rdy_bias);
            clr_ovf  = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coll_event_encoder.md
COLL_EVENT_ENCODER -- requirements
Module: coll_event_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning the number of event input channels (range 1..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of code-queue entries (power of two, 2..64).
REQ-003 SHALL have parameter BASE_CODE, default 8'h40, meaning the code emitted for channel 0.
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 4, meaning the stable-high cycles required when debounce is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port evt_in, input, NUM_CH bits: asynchronous level event inputs.
REQ-008 SHALL have port clr_ovf, input, 1 bit: synchronous clear of the overflow flag.
REQ-009 SHALL have port tx_ready, input, 1 bit: the consumer accepts tx_data.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-011 SHALL have port tx_data, output, 8 bits: the event code.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the current queue occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: a sticky flag indicating an event was lost.

Function
REQ-014 SHALL pass each evt_in bit through a 2-flop synchronizer before any other logic.
REQ-015 SHALL detect a rising edge per channel by comparing the synchronized value with its 1-cycle-delayed copy.
REQ-016 SHALL set pending[i] on the cycle after a rising edge on channel i.
REQ-017 SHALL, each cycle the queue is not full, push the code BASE_CODE+i for the lowest-index set pending[i] and clear that bit in the same cycle.
REQ-018 SHALL push at most one code per cycle.
REQ-019 SHALL issue simultaneous edges on several channels in ascending channel order on consecutive push cycles, with none lost.
REQ-020 SHALL, when a new edge arrives on channel i while pending[i] is still set, drop the event, keep pending[i] set, and set overflow.
REQ-021 SHALL, when the queue is full, hold pending bits unchanged; no push occurs.
REQ-022 SHALL drive tx_valid = queue not empty, with tx_data = the head entry.
REQ-023 SHALL pop the head when tx_valid && tx_ready.
REQ-024 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL allow push and pop in the same cycle when the queue is full: the pop frees the slot, the push is accepted, and fifo_count is unchanged.
REQ-026 SHALL keep fifo_count consistent with the queue occupancy at all times.
REQ-027 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-028 SHALL meet a latency of 4 clk edges from the first edge sampling evt_in high to tx_valid=1, given an empty queue and no other pending channel.
REQ-029 SHALL keep overflow set until clr_ovf=1.
REQ-030 SHALL let a set event take priority over clr_ovf when both occur in the same cycle.

Reset
REQ-031 SHALL, while reset=0, asynchronously clear the synchronizers, edge registers, pending bits, pointers, fifo_count, overflow and tx_valid, and set tx_data=8'h00.
REQ-032 SHALL discard all queued and pending events on reset mid-operation, and not report them after release.
REQ-033 SHALL not generate an edge from an input held high through reset release.

Configuration
REQ-034 SHALL, when COLL_EVT_DEBOUNCE_EN is defined, qualify each synchronized input with a per-channel counter that requires DEBOUNCE_CYC consecutive high cycles before the qualified level rises.
REQ-035 SHALL, in that mode, drop the qualified level on the first low cycle and add DEBOUNCE_CYC cycles to the latency.
REQ-036 SHALL, when COLL_EVT_DEBOUNCE_EN is undefined, generate no counters and feed the synchronized inputs straight to the edge detector.

Structure
REQ-037 SHALL place the event-code typedef (8-bit), the default BASE_CODE and the maximum NUM_CH constant in the shared package coll_evt_pkg.
REQ-038 SHALL implement the queue as the sub-module coll_evt_fifo (synchronous FIFO with push, pop, full, empty and count), instantiated once.

Verification
REQ-039 SHALL cover: single pulse on evt_in[2] with tx_ready=1 -> tx_valid on the 4th edge, tx_data=8'h42, one beat only.
REQ-040 SHALL cover: evt_in[0], [3] and [5] rising in the same cycle -> codes 8'h40, 8'h43, 8'h45 in that order, overflow=0.
REQ-041 SHALL cover: tx_ready=0 with 10 distinct channel edges (NUM_CH=12, FIFO_DEPTH=8) -> fifo_count=8, two pending held, overflow=0; then tx_ready=1 -> all 10 codes out in ascending order.
REQ-042 SHALL cover: queue full and channel 1 pending, second edge on channel 1 -> overflow=1 and exactly one 8'h41 later; clr_ovf=1 -> overflow=0.
REQ-043 SHALL cover: reset=0 asserted with 3 queued entries -> tx_valid=0 and fifo_count=0 immediately; no codes emitted after release.
REQ-044 SHALL cover, with COLL_EVT_DEBOUNCE_EN defined: a 3-cycle high glitch -> no code; a 6-cycle high -> one code.
